// File: rtl/uart_arb_pkg.sv
// Shared state encoding and parameter defaults for the UART TX arbiter.
// Defining UART_ARB_HEADER_EN adds the header state.
package uart_arb_pkg;

    localparam int unsigned NumBytesDefault = 6;
    localparam logic [7:0]  HdrBaseDefault  = 8'hA0;
    localparam int unsigned WordW           = 48;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdEn    = 3'd1,
        StLatch   = 3'd2,
        StSend    = 3'd3,
`ifdef UART_ARB_HEADER_EN
        StHdr     = 3'd5,
`endif
        StWaitAck = 3'd4
    } arb_state_e;

    // Header byte: base with bit 0 replaced by the source ID.
    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic id);
        return (base & 8'hFE) | {7'd0, id};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on contention the source that did not win last time is granted.
// Purely combinational; unaffected by UART_ARB_HEADER_EN.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        unique case (req)
            2'b11:   gnt_id = ~last_grant;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Reads 48-bit words from two FIFOs in round-robin order and streams them LSB byte first
// over a tx_dv/tx_done UART handshake. UART_ARB_HEADER_EN prepends a source header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_BYTES = NumBytesDefault,
    parameter logic [7:0]  HDR_BASE  = HdrBaseDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f0_empty,
    input  logic [WordW-1:0] f0_data,
    output logic             f0_rd_en,
    input  logic             f1_empty,
    input  logic [WordW-1:0] f1_data,
    output logic             f1_rd_en,
    input  logic             tx_done,
    output logic             tx_dv,
    output logic [7:0]       tx_byte,
    output logic             busy,
    output logic             grant_id
);

    localparam logic [2:0] LastIdx = 3'(NUM_BYTES);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             f0_rd_en_q, f0_rd_en_d;
    logic             f1_rd_en_q, f1_rd_en_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             busy_q, busy_d;
    logic [2:0]       idx_q, idx_d;
    logic [WordW-1:0] word_q, word_d;
`ifdef UART_ARB_HEADER_EN
    logic             hdr_pend_q, hdr_pend_d;
`endif

    logic gnt_valid;
    logic gnt_id;

    rr_arb2 u_rr_arb2 (
        .req        ({~f1_empty, ~f0_empty}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        f0_rd_en_d   = 1'b0;
        f1_rd_en_d   = 1'b0;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        idx_d        = idx_q;
        word_d       = word_q;
`ifdef UART_ARB_HEADER_EN
        hdr_pend_d   = hdr_pend_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    f0_rd_en_d   = ~gnt_id;
                    f1_rd_en_d   = gnt_id;
                    grant_id_d   = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = StRdEn;
                end
            end
            StRdEn: state_d = StLatch;
            StLatch: begin
                word_d = grant_id_q ? f1_data : f0_data;
                idx_d  = 3'd0;
`ifdef UART_ARB_HEADER_EN
                state_d = StHdr;
`else
                state_d = StSend;
`endif
            end
`ifdef UART_ARB_HEADER_EN
            StHdr: begin
                tx_byte_d  = hdr_byte(HDR_BASE, grant_id_q);
                tx_dv_d    = 1'b1;
                hdr_pend_d = 1'b1;
                state_d    = StWaitAck;
            end
`endif
            StSend: begin
                if (idx_q < LastIdx) begin
                    tx_byte_d = 8'(word_q >> {idx_q, 3'b000});
                    tx_dv_d   = 1'b1;
                    state_d   = StWaitAck;
                end else begin
                    tx_byte_d = 8'h00;
                    state_d   = StIdle;
                end
            end
            StWaitAck: begin
                // A tx_done coinciding with our own strobe belongs to an earlier byte.
                if (tx_done && !tx_dv_q) begin
`ifdef UART_ARB_HEADER_EN
                    if (hdr_pend_q) begin
                        hdr_pend_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
`else
                    idx_d = idx_q + 3'd1;
`endif
                    state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            f0_rd_en_q   <= 1'b0;
            f1_rd_en_q   <= 1'b0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            busy_q       <= 1'b0;
            idx_q        <= 3'd0;
            word_q       <= '0;
`ifdef UART_ARB_HEADER_EN
            hdr_pend_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            f0_rd_en_q   <= f0_rd_en_d;
            f1_rd_en_q   <= f1_rd_en_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
`ifdef UART_ARB_HEADER_EN
            hdr_pend_q   <= hdr_pend_d;
`endif
        end
    end

    assign f0_rd_en = f0_rd_en_q;
    assign f1_rd_en = f1_rd_en_q;
    assign tx_dv    = tx_dv_q;
    assign tx_byte  = tx_byte_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: FIFO and UART models plus a round-robin reference.
// Expects header bytes when UART_ARB_HEADER_EN is defined.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int unsigned NB = NumBytesDefault;
    localparam logic [7:0]  HB = HdrBaseDefault;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f0_empty = 1'b1;
    logic        f1_empty = 1'b1;
    logic [47:0] f0_data = '0;
    logic [47:0] f1_data = '0;
    logic        tx_done = 1'b0;
    logic        f0_rd_en, f1_rd_en, tx_dv, busy, grant_id;
    logic [7:0]  tx_byte;

    uart_tx_arbiter #(.NUM_BYTES(NB), .HDR_BASE(HB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f0_empty (f0_empty),
        .f0_data  (f0_data),
        .f0_rd_en (f0_rd_en),
        .f1_empty (f1_empty),
        .f1_data  (f1_data),
        .f1_rd_en (f1_rd_en),
        .tx_done  (tx_done),
        .tx_dv    (tx_dv),
        .tx_byte  (tx_byte),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       g;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] q0[$];
    logic [47:0] q1[$];
    logic        grant_log[$];
    logic [7:0]  byte_log[$];
    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          fails = 0;

    int dly_lo = 1, dly_hi = 1;
    bit stall = 0, spur_en = 0, coin_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // FIFO model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (f0_rd_en && q0.size() > 0) f0_data <= q0.pop_front();
        if (f1_rd_en && q1.size() > 0) f1_data <= q1.pop_front();
    end

    // Monitor, reference model and UART responder.
    logic        last_g = 1'b1;
    bit          outst = 0, prev_busy = 0, exp_rd = 0;
    int          cnt = 0;
    logic [7:0]  last_byte = 8'h00;
    logic        rd, src, exp_src;
    logic [47:0] w;
    exp_t        e;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            sb.delete();
            last_g = 1'b1;
            outst = 0;
            cnt = 0;
            prev_busy = 0;
            exp_rd = 0;
            last_byte = 8'h00;
        end else begin
            rd = f0_rd_en | f1_rd_en;
            if (f0_rd_en && f1_rd_en) check("rd_en_exclusive", 1, 0);
            if (prev_busy) check("rd_en_while_busy", {63'd0, rd}, 0);
            else check("rd_en_from_idle", {63'd0, rd}, {63'd0, exp_rd});
            if (rd && !prev_busy) begin
                src = f1_rd_en;
                exp_src = (!f0_empty && !f1_empty) ? ~last_g : f0_empty;
                check("grant_src", {63'd0, src}, {63'd0, exp_src});
                last_g = exp_src;
                grant_log.push_back(src);
                w = '0;
                if (src && q1.size() > 0) w = q1[0];
                if (!src && q0.size() > 0) w = q0[0];
                check("grant_nonempty", (src ? q1.size() : q0.size()) > 0, 1);
`ifdef UART_ARB_HEADER_EN
                sb.push_back('{b: (HB & 8'hFE) | {7'd0, src}, g: src});
`endif
                for (int i = 0; i < int'(NB); i++) sb.push_back('{b: w[i*8 +: 8], g: src});
            end

            if (tx_dv) begin
                if (outst) check("dv_without_ack", 1, 0);
                byte_log.push_back(tx_byte);
                if (sb.size() == 0) begin
                    check("unexpected_byte", {56'd0, tx_byte}, 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("tx_byte", {56'd0, tx_byte}, {56'd0, e.b});
                    check("grant_id", {63'd0, grant_id}, {63'd0, e.g});
                end
                last_byte = tx_byte;
                outst = 1;
                cnt = stall ? 500 : int'($urandom_range(dly_hi, dly_lo));
                // A done pulse alongside the strobe must not count as the acknowledge.
                if (coin_en && $urandom_range(1, 0) == 1) tx_done = 1'b1;
            end else begin
                check("tx_byte_hold", {56'd0, tx_byte}, {56'd0, busy ? last_byte : 8'h00});
                if (outst) begin
                    cnt--;
                    if (cnt <= 0) begin
                        tx_done = 1'b1;
                        outst = 0;
                    end
                end else if (spur_en && $urandom_range(7, 0) == 0) begin
                    tx_done = 1'b1;
                end
            end

            if (prev_busy && !busy) check("word_complete", sb.size(), 0);
            if (!busy) last_byte = 8'h00;
            prev_busy = busy;
        end
        f0_empty = (q0.size() == 0);
        f1_empty = (q1.size() == 0);
        exp_rd = rst_n && !busy && (!f0_empty || !f1_empty);
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_f0_rd_en", {63'd0, f0_rd_en}, 0);
        check("rst_f1_rd_en", {63'd0, f1_rd_en}, 0);
        check("rst_tx_dv", {63'd0, tx_dv}, 0);
        check("rst_tx_byte", {56'd0, tx_byte}, 0);
        check("rst_busy", {63'd0, busy}, 0);
        check("rst_grant_id", {63'd0, grant_id}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int stable = 0;
        for (int i = 0; i < 20000 && stable < 4; i++) begin
            @(negedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && !busy && !f0_rd_en && !f1_rd_en) stable++;
            else stable = 0;
        end
        check({name, "_drain"}, stable >= 4, 1);
    endtask

    task automatic cmp_bytes(input string name);
        check({name, "_len"}, byte_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < byte_log.size(); i++)
            check({name, "_byte"}, {56'd0, byte_log[i]}, {56'd0, exp_q[i]});
    endtask

    initial begin
        logic [63:0] r;
        int          sel;

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        do_reset();

        // Single word, fixed 10-cycle acknowledge.
        dly_lo = 10; dly_hi = 10;
        grant_log.delete(); byte_log.delete(); exp_q.delete();
        q0.push_back(48'h665544332211);
        wait_drain("single");
`ifdef UART_ARB_HEADER_EN
        exp_q.push_back(8'hA0);
`endif
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        cmp_bytes("single");
        check("single_grants", grant_log.size(), 1);
        if (grant_log.size() > 0) check("single_grant_id", {63'd0, grant_log[0]}, 0);

        // Contention from reset: strict alternation starting at source 0.
        do_reset();
        dly_lo = 1; dly_hi = 4;
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            r = {$urandom, $urandom}; q0.push_back(r[47:0]);
            r = {$urandom, $urandom}; q1.push_back(r[47:0]);
        end
        wait_drain("contention");
        check("contention_grants", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size(); i++)
            check("contention_order", {63'd0, grant_log[i]}, i % 2);

        // Back-to-back words from one source.
        grant_log.delete();
        q0.push_back(48'h0102030405AA); q0.push_back(48'h0A0B0C0D0E55);
        wait_drain("b2b");
        check("b2b_grants", grant_log.size(), 2);
        for (int i = 0; i < grant_log.size(); i++)
            check("b2b_src", {63'd0, grant_log[i]}, 0);

        // Long acknowledge stall with spurious and coincident done pulses.
        stall = 1; spur_en = 1; coin_en = 1;
        r = {$urandom, $urandom}; q1.push_back(r[47:0]);
        wait_drain("stall");
        stall = 0;

        // Reset after the third byte, then a fresh word.
        dly_lo = 2; dly_hi = 5;
        byte_log.delete();
        q0.push_back(48'hDEADBEEFCAFE);
        for (int i = 0; i < 5000 && byte_log.size() < 3; i++) @(negedge clk);
        check("midword_progress", byte_log.size() >= 3, 1);
        do_reset();
        byte_log.delete(); grant_log.delete(); exp_q.delete();
        q0.push_back(48'h000000000077);
        wait_drain("after_reset");
`ifdef UART_ARB_HEADER_EN
        exp_q.push_back(8'hA0);
`endif
        exp_q.push_back(8'h77);
        for (int i = 1; i < int'(NB); i++) exp_q.push_back(8'h00);
        cmp_bytes("after_reset");
        check("after_reset_grants", grant_log.size(), 1);

        // Source 1 word; header build adds A1.
        byte_log.delete(); exp_q.delete();
        q1.push_back(48'h0000000000AB);
        wait_drain("hdr");
`ifdef UART_ARB_HEADER_EN
        exp_q.push_back(8'hA1);
`endif
        exp_q.push_back(8'hAB);
        for (int i = 1; i < int'(NB); i++) exp_q.push_back(8'h00);
        cmp_bytes("hdr");

        // Random traffic.
        dly_lo = 1; dly_hi = 6;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(2, 0));
            if (sel != 1) begin r = {$urandom, $urandom}; q0.push_back(r[47:0]); end
            if (sel != 0) begin r = {$urandom, $urandom}; q1.push_back(r[47:0]); end
            repeat ($urandom_range(30, 0)) @(negedge clk);
        end
        wait_drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 6: payload bytes per word. The legal range is 1..6.
REQ-002 SHALL have parameter HDR_BASE, default 8'hA0: header byte base. Bit 0 is replaced by the source ID.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 f0_empty  in  1  source 0 FIFO empty flag.
REQ-006 f0_data  in  48  source 0 FIFO read data; valid one cycle after f0_rd_en.
REQ-007 f0_rd_en  out  1  source 0 FIFO read strobe.
REQ-008 f1_empty, f1_data, f1_rd_en: as REQ-005..007, for source 1.
REQ-009 tx_done  in  1  UART TX byte-complete pulse.
REQ-010 tx_dv  out  1  UART TX start strobe.
REQ-011 tx_byte  out  8  UART TX byte.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 grant_id  out  1  source ID of the word currently being sent.

Function
REQ-014 SHALL use these states: IDLE, RD_EN, LATCH, HDR, SEND, WAIT_ACK.
REQ-015 IDLE: if any source is non-empty, select a source per REQ-016, pulse its rd_en for exactly 1 cycle, and go to RD_EN.
REQ-016 Arbitration is 2-way round robin on last_grant:
- Both sources non-empty: grant !last_grant.
- One source non-empty: grant that source.
- last_grant updates on every grant.
REQ-017 RD_EN: deassert rd_en, then go to LATCH.
REQ-018 LATCH: capture the granted source's 48-bit data, clear the byte index, then go to HDR when headers are enabled, else to SEND.
REQ-019 SEND with index < NUM_BYTES: drive tx_byte = word[index*8 +: 8] (LSB byte first), pulse tx_dv for 1 cycle, and go to WAIT_ACK.
REQ-020 SEND with index == NUM_BYTES: go to IDLE.
REQ-021 WAIT_ACK: on tx_done, increment the index and go to SEND; otherwise hold.
REQ-022 tx_done SHALL be ignored in every state except WAIT_ACK. This includes a tx_done in the same cycle as tx_dv.
REQ-023 The index SHALL be 3 bits wide and SHALL never wrap; the maximum value it reaches is NUM_BYTES.
REQ-024 tx_dv SHALL never be asserted twice without an intervening accepted tx_done.
REQ-025 f0_rd_en and f1_rd_en SHALL be mutually exclusive.
REQ-026 At most one rd_en pulse per word.
REQ-027 No new rd_en SHALL be issued while busy.
REQ-028 A word SHALL occupy IDLE->IDLE for at least NUM_BYTES+3 cycles plus the tx_done waits.
REQ-029 An empty flag that rises after the grant SHALL NOT affect the word in flight.
REQ-030 tx_byte SHALL hold its last value between strobes and return to 0 in IDLE.

Reset
REQ-031 rst_n low SHALL force, asynchronously:
- state=IDLE
- f0_rd_en=f1_rd_en=0
- tx_dv=0
- tx_byte=0
- busy=0
- grant_id=0
- index=0
- last_grant=1, so source 0 wins first
REQ-032 A reset mid-word SHALL discard the latched word and its remaining bytes; after release, sending resumes only from IDLE with a fresh read.

Configuration
REQ-033 With UART_ARB_HEADER_EN defined, the HDR state SHALL send (HDR_BASE & 8'hFE) | grant_id using the same tx_dv/WAIT_ACK handshake before the payload (NUM_BYTES+1 bytes per word). WAIT_ACK after the header returns to SEND with index 0.
REQ-034 Without UART_ARB_HEADER_EN, the HDR state SHALL NOT exist and LATCH SHALL go directly to SEND.

Structure
REQ-035 Package uart_arb_pkg SHALL hold the state encoding constants, the NUM_BYTES default, and the HDR_BASE default.
REQ-036 Round-robin selection SHALL be the sub-module rr_arb2, with:
- inputs: req[1:0], last_grant
- outputs: gnt_valid, gnt_id
- purely combinational

Verification
REQ-037 Single word: f0 holds 48'h665544332211 with f1 empty; tx_done 10 cycles after each tx_dv -> tx_byte sequence 11,22,33,44,55,66, one f0_rd_en pulse, grant_id=0.
REQ-038 Contention: both sources non-empty continuously with 3 words each -> grant order 0,1,0,1,0,1; rd_en signals never overlap.
REQ-039 Handshake: tx_done held low for 500 cycles in WAIT_ACK -> tx_dv stays 0 and tx_byte is stable; a spurious tx_done in SEND or IDLE -> no index advance.
REQ-040 Reset mid-word: rst_n low after byte 3 -> outputs go to 0 immediately; after release, the next word starts with a fresh rd_en and byte 0.
REQ-041 Header build: with UART_ARB_HEADER_EN and f1 data 48'h0000000000AB -> bytes A1,AB,00,00,00,00,00.
REQ-042 Back-to-back: f0 non-empty again at the return to IDLE -> next f0_rd_en exactly 1 cycle after IDLE entry.
